// File: rtl/maxpool_window_sequencer.sv
// maxpool_window_sequencer: 2x2 / stride-2 signed max-pooling sequencer.
// Walks the conv result map window by window in raster order, issues four
// reads per window, keeps the running signed max and writes one pooled value
// per window. Optional build macro MAXPOOL_RELU_EN clamps negative pooled
// values to zero before they are written.
module maxpool_window_sequencer #(
    parameter int unsigned IMG_W      = 26,
    parameter int unsigned IMG_H      = 26,
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned ADDR_W     = 10,
    parameter int unsigned OUT_ADDR_W = 8,
    parameter int unsigned RD_LAT     = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  rd_en,
    output logic [ADDR_W-1:0]     rd_addr,
    input  logic [DATA_W-1:0]     rd_data,
    output logic                  wr_en,
    output logic [OUT_ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0]     wr_data,
    output logic [OUT_ADDR_W-1:0] win_count
);

    localparam int unsigned PW   = IMG_W / 2;
    localparam int unsigned PH   = IMG_H / 2;
    localparam int unsigned PC_W = $clog2(PW + 1);
    localparam int unsigned PR_W = $clog2(PH + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_WRITE,
        S_DONE
    } state_t;

    state_t                r_state;
    state_t                w_state_n;

    logic [1:0]            r_k;
    logic [1:0]            w_k_n;
    logic [PC_W-1:0]       r_pc;
    logic [PC_W-1:0]       w_pc_n;
    logic [PR_W-1:0]       r_pr;
    logic [PR_W-1:0]       w_pr_n;

    logic                  r_rd_en;
    logic                  w_rd_en_n;
    logic                  r_rd_first;
    logic                  w_rd_first_n;
    logic                  r_rd_last;
    logic                  w_rd_last_n;
    logic [ADDR_W-1:0]     r_rd_addr;
    logic [ADDR_W-1:0]     w_rd_addr_n;
    logic                  w_issue;

    logic                  r_wr_en;
    logic                  w_wr_en_n;
    logic [OUT_ADDR_W-1:0] r_wr_addr;
    logic [OUT_ADDR_W-1:0] w_wr_addr_n;
    logic [DATA_W-1:0]     r_wr_data;
    logic [DATA_W-1:0]     w_wr_data_n;
    logic [OUT_ADDR_W-1:0] r_win_count;
    logic [OUT_ADDR_W-1:0] w_win_count_n;
    logic                  r_busy;
    logic                  w_busy_n;
    logic                  r_done;
    logic                  w_done_n;

    // Read-return tracking: valid / first / last flags delayed by the memory latency
    logic [RD_LAT-1:0]     r_vld_sr;
    logic [RD_LAT-1:0]     r_first_sr;
    logic [RD_LAT-1:0]     r_last_sr;
    logic                  w_data_vld;
    logic                  w_data_first;
    logic                  w_data_last;

    logic [DATA_W-1:0]     r_max;
    logic [DATA_W-1:0]     w_max_next;
    logic [DATA_W-1:0]     w_pool;
    logic                  w_last_win;

    // Conv memory address of element k of window (pr, pc)
    function automatic logic [ADDR_W-1:0] elem_addr(
        input logic [PR_W-1:0] pr,
        input logic [PC_W-1:0] pc,
        input logic [1:0]      k
    );
        int unsigned row;
        int unsigned col;
        row = 2 * 32'(pr) + 32'(k[1]);
        col = 2 * 32'(pc) + 32'(k[0]);
        return ADDR_W'(row * IMG_W + col);
    endfunction

    assign w_data_vld   = r_vld_sr[RD_LAT-1];
    assign w_data_first = r_first_sr[RD_LAT-1];
    assign w_data_last  = r_last_sr[RD_LAT-1];
    assign w_last_win   = (r_pc == PC_W'(PW - 1)) && (r_pr == PR_W'(PH - 1));

    // Running max including the sample returning this cycle; first element seeds it
    always_comb begin
        w_max_next = r_max;
        if (w_data_first) begin
            w_max_next = rd_data;
        end else if ($signed(rd_data) > $signed(r_max)) begin
            w_max_next = rd_data;
        end
    end

    // Value written for a window (optionally rectified)
`ifdef MAXPOOL_RELU_EN
    assign w_pool = w_max_next[DATA_W-1] ? '0 : w_max_next;
`else
    assign w_pool = w_max_next;
`endif

    // Next-state and next-output logic
    always_comb begin
        w_state_n     = r_state;
        w_k_n         = r_k;
        w_pc_n        = r_pc;
        w_pr_n        = r_pr;
        w_issue       = 1'b0;
        w_rd_en_n     = 1'b0;
        w_rd_first_n  = 1'b0;
        w_rd_last_n   = 1'b0;
        w_rd_addr_n   = r_rd_addr;
        w_wr_en_n     = 1'b0;
        w_wr_addr_n   = r_wr_addr;
        w_wr_data_n   = r_wr_data;
        w_win_count_n = r_win_count;
        w_busy_n      = r_busy;
        w_done_n      = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_busy_n = 1'b0;
                if (start) begin
                    w_state_n     = S_READ;
                    w_win_count_n = '0;
                    w_pc_n        = '0;
                    w_pr_n        = '0;
                    w_k_n         = 2'd0;
                    w_issue       = 1'b1;
                    w_busy_n      = 1'b1;
                end
            end
            S_READ: begin
                if (r_k == 2'd3) begin
                    w_state_n = S_WAIT;
                end else begin
                    w_k_n   = r_k + 2'd1;
                    w_issue = 1'b1;
                end
            end
            S_WAIT: begin
                if (w_data_vld && w_data_last) begin
                    w_state_n     = S_WRITE;
                    w_wr_en_n     = 1'b1;
                    w_wr_addr_n   = r_win_count;
                    w_wr_data_n   = w_pool;
                    w_win_count_n = r_win_count + OUT_ADDR_W'(1);
                end
            end
            S_WRITE: begin
                if (w_last_win) begin
                    w_state_n = S_DONE;
                    w_done_n  = 1'b1;
                end else begin
                    if (r_pc == PC_W'(PW - 1)) begin
                        w_pc_n = '0;
                        w_pr_n = r_pr + PR_W'(1);
                    end else begin
                        w_pc_n = r_pc + PC_W'(1);
                    end
                    w_k_n     = 2'd0;
                    w_issue   = 1'b1;
                    w_state_n = S_READ;
                end
            end
            S_DONE: begin
                w_state_n = S_IDLE;
                w_busy_n  = 1'b0;
            end
            default: begin
                w_state_n = S_IDLE;
                w_busy_n  = 1'b0;
            end
        endcase

        if (w_issue) begin
            w_rd_en_n    = 1'b1;
            w_rd_first_n = (w_k_n == 2'd0);
            w_rd_last_n  = (w_k_n == 2'd3);
            w_rd_addr_n  = elem_addr(w_pr_n, w_pc_n, w_k_n);
        end
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_k         <= 2'd0;
            r_pc        <= '0;
            r_pr        <= '0;
            r_rd_en     <= 1'b0;
            r_rd_first  <= 1'b0;
            r_rd_last   <= 1'b0;
            r_rd_addr   <= '0;
            r_wr_en     <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_win_count <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_state_n;
            r_k         <= w_k_n;
            r_pc        <= w_pc_n;
            r_pr        <= w_pr_n;
            r_rd_en     <= w_rd_en_n;
            r_rd_first  <= w_rd_first_n;
            r_rd_last   <= w_rd_last_n;
            r_rd_addr   <= w_rd_addr_n;
            r_wr_en     <= w_wr_en_n;
            r_wr_addr   <= w_wr_addr_n;
            r_wr_data   <= w_wr_data_n;
            r_win_count <= w_win_count_n;
            r_busy      <= w_busy_n;
            r_done      <= w_done_n;
        end
    end

    // Delay read strobes by RD_LAT so returning data is tagged; reset drops in-flight reads
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld_sr   <= '0;
            r_first_sr <= '0;
            r_last_sr  <= '0;
        end else begin
            r_vld_sr   <= RD_LAT'({r_vld_sr, r_rd_en});
            r_first_sr <= RD_LAT'({r_first_sr, r_rd_first});
            r_last_sr  <= RD_LAT'({r_last_sr, r_rd_last});
        end
    end

    // Running max register, updated on every returning sample
    always_ff @(posedge clk) begin
        if (rst) begin
            r_max <= '0;
        end else if (w_data_vld) begin
            r_max <= w_max_next;
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign rd_en     = r_rd_en;
    assign rd_addr   = r_rd_addr;
    assign wr_en     = r_wr_en;
    assign wr_addr   = r_wr_addr;
    assign wr_data   = r_wr_data;
    assign win_count = r_win_count;

endmodule

// File: tb/tb_maxpool_window_sequencer.sv
// Bench for maxpool_window_sequencer: default 26x26/RD_LAT=1 instance plus a
// 5x5/RD_LAT=2 instance. Expected pooled writes come from a bench model of the
// memory contents, queued at start and popped as the DUT writes.
module tb_maxpool_window_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        start_s;

    logic        busy, done, rd_en, wr_en;
    logic [9:0]  rd_addr;
    logic [15:0] rd_data;
    logic [7:0]  wr_addr, win_count;
    logic [15:0] wr_data;

    logic        busy_s, done_s, rd_en_s, wr_en_s;
    logic [4:0]  rd_addr_s;
    logic [15:0] rd_data_s;
    logic [2:0]  wr_addr_s, win_count_s;
    logic [15:0] wr_data_s;

    logic signed [15:0] mem   [0:675];
    logic signed [15:0] mem_s [0:24];
    logic [15:0]        s1;

    int cyc = 0;
    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        int a;
        int d;
    } exp_t;

    exp_t q[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    maxpool_window_sequencer u_dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .win_count (win_count)
    );

    maxpool_window_sequencer #(
        .IMG_W(5), .IMG_H(5), .DATA_W(16), .ADDR_W(5), .OUT_ADDR_W(3), .RD_LAT(2)
    ) u_dut_s (
        .clk       (clk),
        .rst       (rst),
        .start     (start_s),
        .busy      (busy_s),
        .done      (done_s),
        .rd_en     (rd_en_s),
        .rd_addr   (rd_addr_s),
        .rd_data   (rd_data_s),
        .wr_en     (wr_en_s),
        .wr_addr   (wr_addr_s),
        .wr_data   (wr_data_s),
        .win_count (win_count_s)
    );

    // Conv memory models: one-cycle and two-cycle read latency
    always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

    always @(posedge clk) begin
        s1        <= mem_s[rd_addr_s];
        rd_data_s <= s1;
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int relu(input int v);
`ifdef MAXPOOL_RELU_EN
        return (v < 0) ? 0 : v;
`else
        return v;
`endif
    endfunction

    // Reference pooling of the 26x26 memory into the scoreboard
    task automatic model_push();
        exp_t e;
        int   m;
        int   v;
        int   ad;
        for (int pr = 0; pr < 13; pr++) begin
            for (int pc = 0; pc < 13; pc++) begin
                m = 0;
                for (int k = 0; k < 4; k++) begin
                    ad = (2 * pr + k / 2) * 26 + 2 * pc + k % 2;
                    v  = mem[ad];
                    if (k == 0 || v > m) m = v;
                end
                e.a = pr * 13 + pc;
                e.d = relu(m);
                q.push_back(e);
            end
        end
    endtask

    // One pass on the default instance; optional mid-pass restart and reset
    task automatic run_pass(input int restart_at, input int rst_at);
        int   n;
        int   t0;
        int   n_wr;
        int   n_done;
        int   first_wr;
        int   done_cyc;
        exp_t e;
        q.delete();
        model_push();
        n_wr     = 0;
        n_done   = 0;
        first_wr = -1;
        done_cyc = -1;
        @(negedge clk);
        t0 = cyc;
        while (1'b1) begin
            n = cyc - t0;
            if (n == 1) chk("busy_on", int'(busy), 1);
            if (wr_en) begin
                n_wr++;
                if (first_wr < 0) first_wr = n;
                if (q.size() > 0) begin
                    e = q.pop_front();
                    chk("wr_addr", int'(wr_addr), e.a);
                    chk("wr_data", int'($signed(wr_data)), e.d);
                end else begin
                    chk("wr_extra", n_wr, 169);
                end
            end
            if (done) begin
                n_done++;
                done_cyc = n;
                chk("busy_at_done", int'(busy), 1);
            end
            if (rst_at >= 0 && n == rst_at + 1) begin
                chk("rst_busy", int'(busy), 0);
                chk("rst_rd_en", int'(rd_en), 0);
                chk("rst_wr_en", int'(wr_en), 0);
                chk("rst_win_count", int'(win_count), 0);
                chk("rst_no_done", n_done, 0);
                chk("rst_n_wr", n_wr, 50);
                rst = 1'b0;
                break;
            end
            if (done_cyc >= 0 && n >= done_cyc + 3) break;
            if (n > 1300) begin
                chk("timeout", n, 1015);
                break;
            end
            start = (n == 0) || (n == restart_at);
            rst   = (rst_at >= 0) && (n == rst_at);
            @(negedge clk);
        end
        start = 1'b0;
        rst   = 1'b0;
        if (rst_at < 0) begin
            chk("n_wr", n_wr, 169);
            chk("first_wr", first_wr, 6);
            chk("done_cyc", done_cyc, 1015);
            chk("n_done", n_done, 1);
            chk("win_count", int'(win_count), 169);
            chk("busy_idle", int'(busy), 0);
        end
        q.delete();
    endtask

    // One pass on the 5x5 / RD_LAT=2 instance with read-address checking
    task automatic run_small();
        int   n;
        int   t0;
        int   done_cyc;
        int   n_wr;
        int   n_rd;
        int   m;
        int   v;
        int   ad;
        int   ra[$];
        exp_t qs[$];
        exp_t e;
        for (int i = 0; i < 25; i++) mem_s[i] = 16'($urandom);
        for (int w = 0; w < 4; w++) begin
            m = 0;
            for (int k = 0; k < 4; k++) begin
                ad = (2 * (w / 2) + k / 2) * 5 + 2 * (w % 2) + k % 2;
                ra.push_back(ad);
                v = mem_s[ad];
                if (k == 0 || v > m) m = v;
            end
            e.a = w;
            e.d = relu(m);
            qs.push_back(e);
        end
        done_cyc = -1;
        n_wr     = 0;
        n_rd     = 0;
        @(negedge clk);
        t0 = cyc;
        while (1'b1) begin
            n = cyc - t0;
            if (rd_en_s) begin
                n_rd++;
                if (ra.size() > 0) chk("s_rd_addr", int'(rd_addr_s), ra.pop_front());
                else               chk("s_rd_extra", n_rd, 16);
            end
            if (wr_en_s) begin
                n_wr++;
                chk("s_wr_cyc", n, 7 * n_wr);
                if (qs.size() > 0) begin
                    e = qs.pop_front();
                    chk("s_wr_addr", int'(wr_addr_s), e.a);
                    chk("s_wr_data", int'($signed(wr_data_s)), e.d);
                end else begin
                    chk("s_wr_extra", n_wr, 4);
                end
            end
            if (done_s) done_cyc = n;
            if (done_cyc >= 0 && n >= done_cyc + 2) break;
            if (n > 200) begin
                chk("s_timeout", n, 29);
                break;
            end
            start_s = (n == 0);
            @(negedge clk);
        end
        start_s = 1'b0;
        chk("s_done_cyc", done_cyc, 29);
        chk("s_n_wr", n_wr, 4);
        chk("s_n_rd", n_rd, 16);
        chk("s_win_count", int'(win_count_s), 4);
    endtask

    initial begin
        rst     = 1'b1;
        start   = 1'b0;
        start_s = 1'b0;
        for (int i = 0; i < 676; i++) mem[i] = 16'(i);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_rd_en", int'(rd_en), 0);
        chk("reset_wr_en", int'(wr_en), 0);
        chk("reset_win_count", int'(win_count), 0);
        chk("reset_wr_data", int'(wr_data), 0);

        // Ramp data: window maxima are the bottom-right elements
        run_pass(-1, -1);

        // Uniform negative data with one larger value in window 0
        for (int i = 0; i < 676; i++) mem[i] = -16'sd5;
        mem[26] = -16'sd3;
        run_pass(-1, -1);

        // Random data with window 0 all equal, then one element raised
        for (int i = 0; i < 676; i++) mem[i] = 16'($urandom);
        mem[0] = 16'sd9; mem[1] = 16'sd9; mem[26] = 16'sd9; mem[27] = 16'sd9;
        run_pass(-1, -1);
        mem[1] = 16'sd10;
        run_pass(-1, -1);

        // start pulsed mid-pass must be ignored
        for (int i = 0; i < 676; i++) mem[i] = 16'($urandom);
        run_pass(100, -1);

        // Reset mid-pass, then a clean pass
        run_pass(-1, 300);
        repeat (2) @(negedge clk);
        run_pass(-1, -1);

        // Small odd-sized map with two-cycle read latency
        run_small();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
